// File: rtl/dnc_controller_pkg.sv
// dnc_controller_pkg: state/PHASE encodings and counter width
// shared by the DNC load controller and its nested counter.
package dnc_controller_pkg;

    localparam int CTRL_W = 64;

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_LOAD_W = 3'd1;
    localparam logic [2:0] PH_LOAD_K = 3'd2;
    localparam logic [2:0] PH_LOAD_B = 3'd3;
    localparam logic [2:0] PH_LOAD_X = 3'd4;
    localparam logic [2:0] PH_RUN    = 3'd5;
    localparam logic [2:0] PH_WAIT   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = PH_IDLE,
        ST_LOAD_W = PH_LOAD_W,
        ST_LOAD_K = PH_LOAD_K,
        ST_LOAD_B = PH_LOAD_B,
        ST_LOAD_X = PH_LOAD_X,
        ST_RUN    = PH_RUN,
        ST_WAIT   = PH_WAIT
    } state_t;

endpackage

// File: rtl/dnc_nested_counter.sv
// dnc_nested_counter: 3-level wrap/carry counter (inner, middle, outer).
// Ports: clk, rst, step, size_inner/middle/outer in; first_middle,
// first_outer, last, zero out. Unused levels are given size 1.
module dnc_nested_counter
    import dnc_controller_pkg::*;
#(
    parameter int W = CTRL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic [W-1:0] size_inner,
    input  logic [W-1:0] size_middle,
    input  logic [W-1:0] size_outer,
    output logic         first_middle,
    output logic         first_outer,
    output logic         last,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] idx_in;
    logic [W-1:0] idx_mid;
    logic [W-1:0] idx_out;
    logic         wrap_in;
    logic         wrap_mid;
    logic         wrap_out;

    assign wrap_in  = (idx_in + ONE) == size_inner;
    assign wrap_mid = (idx_mid + ONE) == size_middle;
    assign wrap_out = (idx_out + ONE) == size_outer;

    // The terminal step wraps every level, so the counter is back at
    // zero for the next phase without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_in  <= '0;
            idx_mid <= '0;
            idx_out <= '0;
        end else if (step) begin
            if (wrap_in) begin
                idx_in <= '0;
                if (wrap_mid) begin
                    idx_mid <= '0;
                    idx_out <= wrap_out ? '0 : idx_out + ONE;
                end else begin
                    idx_mid <= idx_mid + ONE;
                end
            end else begin
                idx_in <= idx_in + ONE;
            end
        end
    end

    assign first_middle = (idx_in == '0);
    assign first_outer  = first_middle && (idx_mid == '0);
    assign last         = wrap_in && wrap_mid && wrap_out;
    assign zero         = (size_inner == '0) || (size_middle == '0) ||
                          (size_outer == '0);

endmodule

// File: rtl/dnc_load_controller.sv
// dnc_load_controller: streams W, K, B, X operand words into a DNC core,
// then starts it and waits for completion. Ports: CLK, RST, START, READY,
// SIZE_*_IN, DATA_IN/VALID/READY, DNC_DATA_OUT, DNC_*_ENABLE, DNC_START,
// DNC_READY, PHASE. Macro DNC_BIAS_LOAD_EN enables the LOAD_B phase.
module dnc_load_controller
    import dnc_controller_pkg::*;
#(
    parameter int DATA_SIZE    = 128,
    parameter int CONTROL_SIZE = CTRL_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_X_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_L_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    input  logic                    DATA_IN_VALID,
    output logic                    DATA_IN_READY,
    output logic [DATA_SIZE-1:0]    DNC_DATA_OUT,
    output logic                    DNC_W_IN_L_ENABLE,
    output logic                    DNC_W_IN_X_ENABLE,
    output logic                    DNC_K_IN_I_ENABLE,
    output logic                    DNC_K_IN_L_ENABLE,
    output logic                    DNC_K_IN_K_ENABLE,
    output logic                    DNC_B_IN_ENABLE,
    output logic                    DNC_X_IN_ENABLE,
    output logic                    DNC_START,
    input  logic                    DNC_READY,
    output logic [2:0]              PHASE
);

    localparam logic [CONTROL_SIZE-1:0] ONE = CONTROL_SIZE'(1);

`ifdef DNC_BIAS_LOAD_EN
    localparam state_t AFTER_K = ST_LOAD_B;
`else
    localparam state_t AFTER_K = ST_LOAD_X;
`endif

    state_t                  state;
    state_t                  state_next;
    logic [CONTROL_SIZE-1:0] size_x;
    logic [CONTROL_SIZE-1:0] size_w;
    logic [CONTROL_SIZE-1:0] size_l;
    logic [CONTROL_SIZE-1:0] size_r;
    logic [CONTROL_SIZE-1:0] cnt_in;
    logic [CONTROL_SIZE-1:0] cnt_mid;
    logic [CONTROL_SIZE-1:0] cnt_out;
    logic                    first_mid;
    logic                    first_out;
    logic                    last;
    logic                    zero;
    logic                    load;
    logic                    xfer;
    logic                    phase_done;

    assign load = (state == ST_LOAD_W) || (state == ST_LOAD_K) ||
                  (state == ST_LOAD_B) || (state == ST_LOAD_X);

    // A phase with a zero bound accepts nothing and leaves at once.
    assign DATA_IN_READY = load && !zero;
    assign xfer          = DATA_IN_VALID && DATA_IN_READY;
    assign phase_done    = zero || (xfer && last);

    dnc_nested_counter #(
        .W(CONTROL_SIZE)
    ) u_cnt (
        .clk         (CLK),
        .rst         (RST),
        .step        (xfer),
        .size_inner  (cnt_in),
        .size_middle (cnt_mid),
        .size_outer  (cnt_out),
        .first_middle(first_mid),
        .first_outer (first_out),
        .last        (last),
        .zero        (zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            size_x <= '0;
            size_w <= '0;
            size_l <= '0;
            size_r <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && START) begin
                size_x <= SIZE_X_IN;
                size_w <= SIZE_W_IN;
                size_l <= SIZE_L_IN;
                size_r <= SIZE_R_IN;
            end
        end
    end

    // Loop bounds per phase, inner level first.
    always_comb begin
        state_next = state;
        cnt_in     = ONE;
        cnt_mid    = ONE;
        cnt_out    = ONE;
        unique case (state)
            ST_IDLE: begin
                if (START) state_next = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                cnt_in  = size_x;
                cnt_mid = size_l;
                if (phase_done) state_next = ST_LOAD_K;
            end
            ST_LOAD_K: begin
                cnt_in  = size_w;
                cnt_mid = size_l;
                cnt_out = size_r;
                if (phase_done) state_next = AFTER_K;
            end
            ST_LOAD_B: begin
                cnt_in = size_l;
                if (phase_done) state_next = ST_LOAD_X;
            end
            ST_LOAD_X: begin
                cnt_in = size_x;
                if (phase_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (DNC_READY) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DNC_DATA_OUT      <= '0;
            DNC_W_IN_L_ENABLE <= 1'b0;
            DNC_W_IN_X_ENABLE <= 1'b0;
            DNC_K_IN_I_ENABLE <= 1'b0;
            DNC_K_IN_L_ENABLE <= 1'b0;
            DNC_K_IN_K_ENABLE <= 1'b0;
            DNC_X_IN_ENABLE   <= 1'b0;
        end else begin
            if (xfer) DNC_DATA_OUT <= DATA_IN;
            DNC_W_IN_X_ENABLE <= xfer && (state == ST_LOAD_W);
            DNC_W_IN_L_ENABLE <= xfer && (state == ST_LOAD_W) && first_mid;
            DNC_K_IN_K_ENABLE <= xfer && (state == ST_LOAD_K);
            DNC_K_IN_L_ENABLE <= xfer && (state == ST_LOAD_K) && first_mid;
            DNC_K_IN_I_ENABLE <= xfer && (state == ST_LOAD_K) && first_out;
            DNC_X_IN_ENABLE   <= xfer && (state == ST_LOAD_X);
        end
    end

`ifdef DNC_BIAS_LOAD_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) DNC_B_IN_ENABLE <= 1'b0;
        else     DNC_B_IN_ENABLE <= xfer && (state == ST_LOAD_B);
    end
`else
    assign DNC_B_IN_ENABLE = 1'b0;
`endif

    assign DNC_START = (state == ST_RUN);
    assign READY     = (state == ST_WAIT) && DNC_READY;
    assign PHASE     = state;

endmodule

// File: tb/tb_dnc_load_controller.sv
// tb_dnc_load_controller: directed self-checking bench for
// dnc_load_controller (honours DNC_BIAS_LOAD_EN for expected counts).
module tb_dnc_load_controller;

    localparam int DW = 128;
    localparam int CW = 64;
`ifdef DNC_BIAS_LOAD_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          READY;
    logic [CW-1:0] SIZE_X_IN = '0;
    logic [CW-1:0] SIZE_W_IN = '0;
    logic [CW-1:0] SIZE_L_IN = '0;
    logic [CW-1:0] SIZE_R_IN = '0;
    logic [DW-1:0] DATA_IN = '0;
    logic          DATA_IN_VALID = 1'b0;
    logic          DATA_IN_READY;
    logic [DW-1:0] DNC_DATA_OUT;
    logic          DNC_W_IN_L_ENABLE;
    logic          DNC_W_IN_X_ENABLE;
    logic          DNC_K_IN_I_ENABLE;
    logic          DNC_K_IN_L_ENABLE;
    logic          DNC_K_IN_K_ENABLE;
    logic          DNC_B_IN_ENABLE;
    logic          DNC_X_IN_ENABLE;
    logic          DNC_START;
    logic          DNC_READY = 1'b0;
    logic [2:0]    PHASE;

    dnc_load_controller #(
        .DATA_SIZE(DW),
        .CONTROL_SIZE(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY),
        .SIZE_X_IN(SIZE_X_IN), .SIZE_W_IN(SIZE_W_IN),
        .SIZE_L_IN(SIZE_L_IN), .SIZE_R_IN(SIZE_R_IN),
        .DATA_IN(DATA_IN), .DATA_IN_VALID(DATA_IN_VALID),
        .DATA_IN_READY(DATA_IN_READY), .DNC_DATA_OUT(DNC_DATA_OUT),
        .DNC_W_IN_L_ENABLE(DNC_W_IN_L_ENABLE),
        .DNC_W_IN_X_ENABLE(DNC_W_IN_X_ENABLE),
        .DNC_K_IN_I_ENABLE(DNC_K_IN_I_ENABLE),
        .DNC_K_IN_L_ENABLE(DNC_K_IN_L_ENABLE),
        .DNC_K_IN_K_ENABLE(DNC_K_IN_K_ENABLE),
        .DNC_B_IN_ENABLE(DNC_B_IN_ENABLE),
        .DNC_X_IN_ENABLE(DNC_X_IN_ENABLE),
        .DNC_START(DNC_START), .DNC_READY(DNC_READY), .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] data_base = 128'h0123_4567_89AB_CDEF_0000_0000_0000_1000;
    logic [6:0]    ens;
    assign ens = {DNC_W_IN_L_ENABLE, DNC_W_IN_X_ENABLE, DNC_K_IN_I_ENABLE,
                  DNC_K_IN_L_ENABLE, DNC_K_IN_K_ENABLE, DNC_B_IN_ENABLE,
                  DNC_X_IN_ENABLE};

    // enable-pulse monitor, sampled on the falling edge
    int            n_wx, n_wl, n_kk, n_kl, n_ki, n_b, n_x, n_start, n_bad;
    logic [63:0]   wl_mask, ki_mask;
    logic [DW-1:0] dlog[$];
    logic          last_xfer = 1'b0;

    always @(negedge CLK) begin
        if (DNC_W_IN_X_ENABLE) begin
            if (DNC_W_IN_L_ENABLE) wl_mask[n_wx] = 1'b1;
            n_wx++;
        end
        if (DNC_W_IN_L_ENABLE) n_wl++;
        if (DNC_K_IN_K_ENABLE) begin
            if (DNC_K_IN_I_ENABLE) ki_mask[n_kk] = 1'b1;
            n_kk++;
        end
        if (DNC_K_IN_L_ENABLE) n_kl++;
        if (DNC_K_IN_I_ENABLE) n_ki++;
        if (DNC_B_IN_ENABLE) n_b++;
        if (DNC_X_IN_ENABLE) n_x++;
        if (DNC_START) n_start++;
        if (DNC_W_IN_X_ENABLE || DNC_K_IN_K_ENABLE ||
            DNC_B_IN_ENABLE || DNC_X_IN_ENABLE) begin
            if (!last_xfer) n_bad++;
            dlog.push_back(DNC_DATA_OUT);
        end
    end

    task automatic clear_mon();
        n_wx = 0; n_wl = 0; n_kk = 0; n_kl = 0; n_ki = 0;
        n_b = 0; n_x = 0; n_start = 0; n_bad = 0;
        wl_mask = '0; ki_mask = '0;
        dlog.delete();
    endtask

    task automatic set_sizes(input int x, input int w,
                             input int l, input int r);
        SIZE_X_IN = CW'(x);
        SIZE_W_IN = CW'(w);
        SIZE_L_IN = CW'(l);
        SIZE_R_IN = CW'(r);
    endtask

    // One full sequence: START, stream words, core answers DNC_READY
    // five cycles after DNC_START. Inputs are driven on the falling edge,
    // combinational outputs sampled 1 time unit before the rising edge.
    task automatic run_seq(input bit toggle, input bit hold_start,
                           output int xfers, output int lat,
                           output bit done);
        int since;
        int sent;
        xfers = 0; lat = -1; done = 0; since = -1; sent = 0;
        @(negedge CLK);
        clear_mon();
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) @(negedge CLK);
            if (since >= 0) since++;
            START = (c == 0) || hold_start;
            DATA_IN_VALID = toggle ? (c % 2 == 0) : 1'b1;
            DATA_IN = data_base + DW'(sent);
            DNC_READY = (since == 5);
            #4;
            last_xfer = DATA_IN_VALID && DATA_IN_READY;
            if (last_xfer) begin
                xfers++;
                sent++;
            end
            if (DNC_START && since < 0) since = 0;
            if (READY) begin
                done = 1;
                lat = since;
            end
        end
        @(negedge CLK);
        START = 1'b0;
        DATA_IN_VALID = 1'b0;
        DNC_READY = 1'b0;
        last_xfer = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (PHASE !== 3'd0) begin
            errors++; $display("FAIL reset_phase: got %0d want 0", PHASE);
        end
        checks++;
        if (DNC_DATA_OUT !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", DNC_DATA_OUT);
        end
        checks++;
        if ({ens, DNC_START, READY, DATA_IN_READY} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {ens, DNC_START, READY, DATA_IN_READY});
        end
        RST = 1'b0;
    endtask

    task automatic test_basic();
        int xf, lat;
        bit done;
        set_sizes(2, 1, 2, 1);
        run_seq(1'b0, 1'b0, xf, lat, done);
        checks++;
        if (!done) begin
            errors++; $display("FAIL basic_ready: no READY within budget");
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL basic_latency: got %0d want 5", lat);
        end
        checks++;
        if (n_wx !== 4) begin
            errors++; $display("FAIL basic_w_x: got %0d want 4", n_wx);
        end
        checks++;
        if (wl_mask !== 64'h5) begin
            errors++; $display("FAIL basic_w_l_words: got %h want 5", wl_mask);
        end
        checks++;
        if (n_kk !== 2) begin
            errors++; $display("FAIL basic_k: got %0d want 2", n_kk);
        end
        checks++;
        if (n_b !== 2 * BIAS) begin
            errors++; $display("FAIL basic_b: got %0d want %0d", n_b, 2 * BIAS);
        end
        checks++;
        if (n_x !== 2) begin
            errors++; $display("FAIL basic_x: got %0d want 2", n_x);
        end
        checks++;
        if (xf !== 8 + 2 * BIAS) begin
            errors++;
            $display("FAIL basic_xfers: got %0d want %0d", xf, 8 + 2 * BIAS);
        end
        checks++;
        if (n_start !== 1) begin
            errors++; $display("FAIL basic_start: got %0d want 1", n_start);
        end
        #4;
        checks++;
        if (PHASE !== 3'd0) begin
            errors++; $display("FAIL basic_idle: got %0d want 0", PHASE);
        end
    endtask

    // START held high throughout: ignored outside IDLE and in the
    // completing WAIT cycle.
    task automatic test_k_nesting();
        int xf, lat;
        bit done;
        set_sizes(1, 3, 1, 2);
        run_seq(1'b0, 1'b1, xf, lat, done);
        checks++;
        if (!done) begin
            errors++; $display("FAIL knest_ready: no READY within budget");
        end
        checks++;
        if (n_kk !== 6) begin
            errors++; $display("FAIL knest_k: got %0d want 6", n_kk);
        end
        checks++;
        if (ki_mask !== 64'h9) begin
            errors++; $display("FAIL knest_i_words: got %h want 9", ki_mask);
        end
        checks++;
        if (n_kl !== 2) begin
            errors++; $display("FAIL knest_l: got %0d want 2", n_kl);
        end
        checks++;
        if (xf !== 8 + BIAS) begin
            errors++; $display("FAIL knest_xfers: got %0d want %0d", xf, 8 + BIAS);
        end
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (PHASE !== 3'd0) begin
            errors++; $display("FAIL knest_no_restart: got %0d want 0", PHASE);
        end
    endtask

    task automatic test_stall();
        int xf, lat;
        bit done;
        set_sizes(3, 1, 1, 1);
        run_seq(1'b1, 1'b0, xf, lat, done);
        checks++;
        if (!done) begin
            errors++; $display("FAIL stall_ready: no READY within budget");
        end
        checks++;
        if (n_bad !== 0) begin
            errors++; $display("FAIL stall_enable_timing: got %0d want 0", n_bad);
        end
        checks++;
        if (n_x !== 3) begin
            errors++; $display("FAIL stall_x: got %0d want 3", n_x);
        end
        checks++;
        if (xf !== 7 + BIAS || dlog.size() !== 7 + BIAS) begin
            errors++;
            $display("FAIL stall_count: got %0d/%0d want %0d",
                     xf, dlog.size(), 7 + BIAS);
        end
        for (int i = 0; i < dlog.size(); i++) begin
            checks++;
            if (dlog[i] !== data_base + DW'(i)) begin
                errors++;
                $display("FAIL stall_data[%0d]: got %h want %h",
                         i, dlog[i], data_base + DW'(i));
            end
        end
    endtask

    task automatic test_zero_skip();
        int xf, lat;
        bit done;
        set_sizes(2, 0, 1, 1);
        run_seq(1'b0, 1'b0, xf, lat, done);
        checks++;
        if (!done) begin
            errors++; $display("FAIL zero_ready: no READY within budget");
        end
        checks++;
        if ({n_kk, n_kl, n_ki} !== 96'd0) begin
            errors++;
            $display("FAIL zero_k_enables: got %0d/%0d/%0d want 0",
                     n_kk, n_kl, n_ki);
        end
        checks++;
        if (n_x !== 2) begin
            errors++; $display("FAIL zero_x: got %0d want 2", n_x);
        end
        checks++;
        if (xf !== 4 + BIAS) begin
            errors++; $display("FAIL zero_xfers: got %0d want %0d", xf, 4 + BIAS);
        end
    endtask

    task automatic test_reset_mid();
        int xf, lat, nrdy;
        bit done, hit;
        set_sizes(1, 3, 1, 1);
        @(negedge CLK);
        clear_mon();
        START = 1'b1;
        DATA_IN_VALID = 1'b1;
        DATA_IN = data_base + DW'(77);
        last_xfer = 1'b1;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge CLK);
            START = 1'b0;
            #1;
            if (n_kk >= 1) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rstmid_reach_k: LOAD_K word 1 not seen");
        end
        RST = 1'b1;
        #1;
        checks++;
        if (PHASE !== 3'd0) begin
            errors++; $display("FAIL rstmid_phase: got %0d want 0", PHASE);
        end
        checks++;
        if (DNC_DATA_OUT !== '0) begin
            errors++; $display("FAIL rstmid_data: got %h want 0", DNC_DATA_OUT);
        end
        checks++;
        if ({ens, DNC_START, READY, DATA_IN_READY} !== 10'd0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b want 0",
                     {ens, DNC_START, READY, DATA_IN_READY});
        end
        @(negedge CLK);
        RST = 1'b0;
        DATA_IN_VALID = 1'b0;
        last_xfer = 1'b0;
        DNC_READY = 1'b1;
        nrdy = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            #4;
            if (READY) nrdy++;
        end
        DNC_READY = 1'b0;
        checks++;
        if (nrdy !== 0) begin
            errors++; $display("FAIL rstmid_no_ready: got %0d want 0", nrdy);
        end
        checks++;
        if (PHASE !== 3'd0) begin
            errors++; $display("FAIL rstmid_idle: got %0d want 0", PHASE);
        end
        run_seq(1'b0, 1'b0, xf, lat, done);
        checks++;
        if (!done || n_wx !== 1 || n_kk !== 3) begin
            errors++;
            $display("FAIL rstmid_replay: done=%0d w=%0d k=%0d want 1/1/3",
                     done, n_wx, n_kk);
        end
        checks++;
        if (xf !== 5 + BIAS) begin
            errors++;
            $display("FAIL rstmid_replay_xfers: got %0d want %0d", xf, 5 + BIAS);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_k_nesting();
        test_stall();
        test_zero_skip();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dnc_load_controller.md
DNC_LOAD_CONTROLLER -- requirements
Module: dnc_load_controller

Interface
REQ-001 Parameter DATA_SIZE, default 128: width of the data word.
REQ-002 Parameter CONTROL_SIZE, default 64: width of the size and counter fields.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high. Ports are named CLK and RST.
REQ-004 CLK  in  1  clock.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 START  in  1  begins one load/run sequence; sampled only in IDLE.
REQ-007 READY  out  1  one-cycle pulse on sequence completion.
REQ-008 SIZE_X_IN, SIZE_W_IN, SIZE_L_IN, SIZE_R_IN  in  CONTROL_SIZE each  loop bounds; latched on accepted START.
REQ-009 DATA_IN  in  DATA_SIZE  source word.
REQ-010 DATA_IN_VALID  in  1  source word valid.
REQ-011 DATA_IN_READY  out  1  controller accepts a word.
REQ-012 DNC_DATA_OUT  out  DATA_SIZE  registered word driven to the DNC core.
REQ-013 DNC_W_IN_L_ENABLE, DNC_W_IN_X_ENABLE, DNC_K_IN_I_ENABLE, DNC_K_IN_L_ENABLE, DNC_K_IN_K_ENABLE, DNC_B_IN_ENABLE, DNC_X_IN_ENABLE  out  1 each  core loop enables.
REQ-014 DNC_START  out  1  core start pulse.
REQ-015 DNC_READY  in  1  core completion.
REQ-016 PHASE  out  3  current FSM state encoding.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD_W, LOAD_K, LOAD_B, LOAD_X, RUN and WAIT.
- IDLE -> LOAD_W on START.
- Load states advance in the order LOAD_W -> LOAD_K -> LOAD_B -> LOAD_X.
- LOAD_X exits to RUN.
- RUN -> WAIT after 1 cycle.
- WAIT -> IDLE on DNC_READY.
REQ-018 Loop counts per phase:
- LOAD_W: L x X words, l outer, x inner.
- LOAD_K: R x L x W words, i outer, l middle, k inner.
- LOAD_B: L words.
- LOAD_X: X words.
REQ-019 DATA_IN_READY SHALL be 1 only in load states; a transfer is a cycle with DATA_IN_VALID and DATA_IN_READY both 1.
REQ-020 On each transfer, the next cycle SHALL have DNC_DATA_OUT equal to the transferred word and the innermost enable of the phase pulsed for one cycle; latency is 1 cycle.
REQ-021 Each outer or middle enable SHALL pulse in the same cycle as the inner enable for the first word of its index.
REQ-022 Counters SHALL be CONTROL_SIZE wide, count from 0 to size-1, wrap to 0 and carry to the next level; the terminal transfer of a phase changes state.
REQ-023 A phase with any zero bound SHALL be skipped in one cycle, with no enables and no transfers.
REQ-024 DNC_START SHALL pulse exactly one cycle in RUN.
REQ-025 READY SHALL pulse in the cycle WAIT observes DNC_READY; the FSM is in IDLE in the following cycle.
REQ-026 START outside IDLE SHALL be ignored.
REQ-027 DNC_READY outside WAIT SHALL be ignored.
REQ-028 DATA_IN_VALID deasserted SHALL stall the counters without dropping state.
REQ-029 START together with DNC_READY in the same cycle while in WAIT SHALL complete the current sequence only; START is not accepted that cycle.

Reset
REQ-030 RST asserted SHALL immediately force:
- state IDLE, PHASE = 0;
- all counters and latched sizes = 0;
- DNC_DATA_OUT = 0;
- all enables, DNC_START, READY and DATA_IN_READY = 0.
REQ-031 Reset mid-sequence SHALL abandon the sequence; no READY pulse is produced.

Configuration
REQ-032 Macro DNC_BIAS_LOAD_EN:
- Defined: LOAD_B is present as specified above.
- Undefined: LOAD_K proceeds directly to LOAD_X, DNC_B_IN_ENABLE is constant 0, and the PHASE encoding is unchanged.

Structure
REQ-033 A shared package dnc_controller_pkg SHALL hold the state enum, the PHASE encodings and the counter width constant.
REQ-034 One sub-module, dnc_nested_counter, SHALL implement a 3-level configurable wrap/carry counter with first-index and terminal flags; each load phase reuses it.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- X=2, L=2, R=1, W=1, source always valid: 4 W transfers; DNC_W_IN_L_ENABLE pulses on words 1 and 3; 2 K transfers; 2 B transfers; 2 X transfers; then DNC_START; DNC_READY after 5 cycles -> READY pulse.
- R=2, L=1, W=3: 6 K transfers; DNC_K_IN_I_ENABLE pulses on words 1 and 4; DNC_K_IN_K_ENABLE pulses 6 times.
- DATA_IN_VALID toggling every other cycle, X=3, L=1: enables pulse only after valid cycles; DNC_DATA_OUT sequence equals the input sequence.
- SIZE_W_IN=0: LOAD_K skipped, zero K enables, X load still occurs.
- RST pulsed during LOAD_K word 2: all outputs 0 at once, no READY; a fresh START replays from LOAD_W.
- DNC_BIAS_LOAD_EN undefined: no DNC_B_IN_ENABLE pulses; total transfers = L*X + R*L*W + X.
